uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter among N byte-producing requesters using round-robin arbitration.
- Per grant, sequences a frame into the transmitter: an optional ID byte, then the requester's payload byte.
- Drives the transmitter's byte/data-valid inputs and tracks its active flag to detect frame start and end.
- Sits between the control/telemetry producers and the single serial TX line.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte producers.
// Each grant sends an optional ID byte (ID_BASE + index) followed by the payload byte.
module uart_tx_arbiter #(
  parameter int         N             = 4,
  parameter bit         SEND_ID       = 1'b1,
  parameter logic [7:0] ID_BASE       = 8'hA0,
  parameter int         START_TIMEOUT = 64,
  parameter int         GAP_CYCLES    = 2,
  localparam int        GW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     tx_byte,
  output logic           tx_dv,
  input  logic           tx_active,
  output logic [GW-1:0]  grant_id,
  output logic           busy,
  output logic           timeout_err
);

  localparam int TW       = $clog2(START_TIMEOUT + 1);
  localparam int PW       = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] r_grant;
  logic [7:0]    r_payload;
  logic          r_phase_id;
  logic [TW-1:0] r_to_cnt;
  logic [PW-1:0] r_gap_cnt;
  logic [N-1:0]  r_req_ready;
  logic [7:0]    r_tx_byte;
  logic          r_tx_dv;
  logic          r_busy;
  logic          r_timeout;

  logic          w_found;
  logic [GW-1:0] w_sel;
  logic [7:0]    w_data;
  logic [GW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_onehot;

  // Round-robin search: first pending requester at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N; k++) begin
      w_sel   = (!w_found && req_valid[(int'(r_ptr) + k) % N]) ? GW'((int'(r_ptr) + k) % N) : w_sel;
      w_found = w_found | req_valid[(int'(r_ptr) + k) % N];
    end
  end

  assign w_data    = req_data[8*int'(w_sel) +: 8];
  assign w_ptr_nxt = (int'(r_grant) == N - 1) ? '0 : r_grant + GW'(1);
  assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << r_grant;

  // Frame sequencer; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_payload   <= 8'h00;
      r_phase_id  <= 1'b0;
      r_to_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_req_ready <= '0;
      r_tx_byte   <= 8'h00;
      r_tx_dv     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_tx_dv     <= 1'b0;
      r_req_ready <= '0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_sel;
            r_payload  <= w_data;
            r_phase_id <= SEND_ID;
            r_tx_byte  <= SEND_ID ? (ID_BASE + 8'(w_sel)) : w_data;
            r_tx_dv    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The tx_dv cycle itself counts toward the start timeout.
          r_to_cnt <= TW'(1);
          r_state  <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (tx_active) begin
            r_state <= S_WAIT_DONE;
          end else if (r_to_cnt >= TW'(START_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_ptr     <= w_ptr_nxt;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_active) begin
            if (r_phase_id) begin
              r_phase_id <= 1'b0;
              r_tx_byte  <= r_payload;
              r_tx_dv    <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_req_ready <= w_onehot;
              r_ptr       <= w_ptr_nxt;
              r_gap_cnt   <= '0;
              r_state     <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt >= PW'(GAP_LAST)) begin
            r_tx_byte <= 8'h00;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + PW'(1);
          end
        end
        default: begin
          r_tx_byte <= 8'h00;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_byte     = r_tx_byte;
  assign tx_dv       = r_tx_dv;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance A (ID bytes, GAP=2) and instance B (payload only, GAP=0),
// each driving a small behavioural transmitter that holds tx_active for a fixed byte time.
module tb_uart_tx_arbiter;

  localparam int BYTE_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_req = 4'h0, a_ready, b_req = 4'h0, b_ready;
  logic [31:0] a_data = 32'h0, b_data = 32'h0;
  logic [7:0]  a_byte, b_byte;
  logic        a_dv, a_act, a_busy, a_to, b_dv, b_act, b_busy, b_to;
  logic [1:0]  a_grant, b_grant;
  logic        a_stuck = 1'b0;
  int          a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int a_dv_cyc, a_to_cyc, a_rdy_cyc, a_fall_cyc, b_rdy_cyc, b_fall_cyc;
  logic a_busy_q = 1'b0, b_busy_q = 1'b0;
  logic [7:0] a_log[$], b_log[$];
  logic [3:0] a_srv[$], b_srv[$];

  uart_tx_arbiter #(.N(4), .SEND_ID(1'b1), .ID_BASE(8'hA0), .START_TIMEOUT(64), .GAP_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(rst), .req_valid(a_req), .req_data(a_data), .req_ready(a_ready),
    .tx_byte(a_byte), .tx_dv(a_dv), .tx_active(a_act), .grant_id(a_grant), .busy(a_busy),
    .timeout_err(a_to));

  uart_tx_arbiter #(.N(4), .SEND_ID(1'b0), .ID_BASE(8'hA0), .START_TIMEOUT(64), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(rst), .req_valid(b_req), .req_data(b_data), .req_ready(b_ready),
    .tx_byte(b_byte), .tx_dv(b_dv), .tx_active(b_act), .grant_id(b_grant), .busy(b_busy),
    .timeout_err(b_to));

  // Transmitter models: tx_active rises the cycle after tx_dv and lasts BYTE_CYC cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_act <= 1'b0; a_cnt <= 0; b_act <= 1'b0; b_cnt <= 0;
    end else begin
      if (a_stuck) begin
        a_act <= 1'b0; a_cnt <= 0;
      end else if (a_dv) begin
        a_act <= 1'b1; a_cnt <= BYTE_CYC;
      end else if (a_cnt != 0) begin
        a_cnt <= a_cnt - 1;
        if (a_cnt == 1) a_act <= 1'b0;
      end
      if (b_dv) begin
        b_act <= 1'b1; b_cnt <= BYTE_CYC;
      end else if (b_cnt != 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) b_act <= 1'b0;
      end
    end
  end

  // Monitor: logs sent bytes, completion pulses and event cycles mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (a_dv) begin a_log.push_back(a_byte); a_dv_cyc <= cyc; end
    if (b_dv) b_log.push_back(b_byte);
    if (a_ready != 4'h0) begin a_srv.push_back(a_ready); a_rdy_cyc <= cyc; end
    if (b_ready != 4'h0) begin b_srv.push_back(b_ready); b_rdy_cyc <= cyc; end
    if (a_to) a_to_cyc <= cyc;
    if (a_busy_q && !a_busy) a_fall_cyc <= cyc;
    if (b_busy_q && !b_busy) b_fall_cyc <= cyc;
    a_busy_q <= a_busy;
    b_busy_q <= b_busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for n completion pulses on instance A (sel=0) or B (sel=1), dropping each served request.
  task automatic wait_srv(input bit sel, input int n, input string tag);
    int k = 0;
    int c = 0;
    while (k < n && c < 2000) begin
      @(negedge clk);
      c++;
      if (!sel && a_ready != 4'h0) begin a_req = a_req & ~a_ready; k++; end
      if (sel && b_ready != 4'h0) begin b_req = b_req & ~b_ready; k++; end
    end
    #1;
    check_eq(tag, k, n);
  endtask

  // Waits for an A-side event: 0 = tx_active, 1 = tx_dv, 2 = timeout_err.
  task automatic wait_a(input int what, input string tag);
    int c = 0;
    logic hit = 1'b0;
    while (!hit && c < 500) begin
      @(negedge clk);
      c++;
      hit = (what == 0) ? a_act : (what == 1) ? a_dv : a_to;
    end
    #1;
    check_eq(tag, hit, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] exp3_log [10] = '{8'hA0, 8'h12, 8'hA1, 8'h33, 8'hA2, 8'h9F, 8'hA3, 8'hFF, 8'hA0, 8'h12};
  logic [3:0] exp3_srv [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_idle", {a_ready, a_byte, a_dv, a_grant, a_busy, a_to}, 32'h0);

    // Reset while the ID byte is in flight.
    a_data = 32'h00B3_0000;
    a_req  = 4'b0100;
    wait_a(0, "t1_active");
    @(negedge clk);
    check_eq("t1_busy_pre", a_busy, 1'b1);
    check_eq("t1_grant_pre", a_grant, 2'd2);
    #2 rst = 1'b0;
    #1;
    check_eq("t1_outs_zero", {a_ready, a_byte, a_dv, a_grant, a_busy, a_to}, 32'h0);
    a_req = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    a_log.delete(); a_srv.delete();
    repeat (6) @(negedge clk);
    #1;
    check_eq("t1_stay_idle", a_busy, 1'b0);
    check_eq("t1_no_bytes", a_log.size(), 0);
    check_eq("t1_no_ready", a_srv.size(), 0);

    // Single request from requester 2.
    a_req = 4'b0100;
    wait_srv(1'b0, 1, "t2_done");
    repeat (4) @(negedge clk);
    #1;
    check_eq("t2_nbytes", a_log.size(), 2);
    check_eq("t2_byte0", a_log[0], 8'hA2);
    check_eq("t2_byte1", a_log[1], 8'hB3);
    check_eq("t2_ready", a_srv[0], 4'b0100);
    check_eq("t2_nready", a_srv.size(), 1);
    check_eq("t2_busy_fall", a_fall_cyc - a_rdy_cyc, 2);

    // Payload-only instance with the pointer moved to 1 first.
    b_data = 32'h0000_00FF;
    b_req  = 4'b0001;
    wait_srv(1'b1, 1, "t4_pre");
    b_log.delete(); b_srv.delete();
    b_data = 32'h0000_00FF;
    b_req  = 4'b1001;
    wait_srv(1'b1, 2, "t4_done");
    repeat (3) @(negedge clk);
    #1;
    check_eq("t4_nbytes", b_log.size(), 2);
    check_eq("t4_byte0", b_log[0], 8'h00);
    check_eq("t4_byte1", b_log[1], 8'hFF);
    check_eq("t4_srv0", b_srv[0], 4'b1000);
    check_eq("t4_srv1", b_srv[1], 4'b0001);
    check_eq("t4_busy_fall", b_fall_cyc - b_rdy_cyc, 1);

    // All four pending; requester 0 re-requests right after its service.
    do_reset();
    a_log.delete(); a_srv.delete();
    a_data = 32'hFF9F_3312;
    a_req  = 4'b1111;
    wait_srv(1'b0, 1, "t3_first");
    a_req[0] = 1'b1;
    wait_srv(1'b0, 4, "t3_rest");
    repeat (4) @(negedge clk);
    #1;
    check_eq("t3_nbytes", a_log.size(), 10);
    for (int i = 0; i < 10; i++) check_eq($sformatf("t3_byte%0d", i), a_log[i], exp3_log[i]);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t3_srv%0d", i), a_srv[i], exp3_srv[i]);

    // Stuck transmitter: requester 1 times out, requester 2 goes next, 1 is retried.
    a_log.delete(); a_srv.delete();
    a_stuck = 1'b1;
    a_data  = 32'h0055_4400;
    a_req   = 4'b0110;
    wait_a(2, "t5_timeout_seen");
    check_eq("t5_timeout_delay", a_to_cyc - a_dv_cyc, 64);
    check_eq("t5_no_ready", a_srv.size(), 0);
    check_eq("t5_first_id", a_log[0], 8'hA1);
    a_stuck = 1'b0;
    wait_a(1, "t5_next_dv");
    check_eq("t5_next_grant", a_grant, 2'd2);
    check_eq("t5_next_byte", a_byte, 8'hA2);
    wait_srv(1'b0, 2, "t5_done");
    check_eq("t5_srv0", a_srv[0], 4'b0100);
    check_eq("t5_srv1", a_srv[1], 4'b0010);
    check_eq("t5_nbytes", a_log.size(), 5);
    check_eq("t5_retry_data", a_log[4], 8'h44);
    repeat (4) @(negedge clk);

    // Requester 3 drops req_valid and changes its data mid-frame.
    a_log.delete(); a_srv.delete();
    a_data = 32'h5C00_0000;
    a_req  = 4'b1000;
    wait_a(0, "t6_active");
    a_req  = 4'b0000;
    a_data = 32'h0000_0000;
    wait_srv(1'b0, 1, "t6_done");
    check_eq("t6_ready", a_srv[0], 4'b1000);
    check_eq("t6_byte0", a_log[0], 8'hA3);
    check_eq("t6_byte1", a_log[1], 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
